// File: rtl/pe_packet_sender.sv
// Packet transmitter feeding one PE input port: captures a filter row and an
// ifmap spike row, then streams clear, filter and per-window ifmap packets.
module pe_packet_sender #(
  parameter int IFMAP_W    = 8,
  parameter bit SEND_CLEAR = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [23:0]        filter_in_i,
  input  logic [IFMAP_W-1:0] ifmap_in_i,
  output logic               idle_o,
  output logic [25:0]        pkt_data_o,
  output logic               pkt_valid_o,
  input  logic               pkt_ready_i,
  output logic               done_o
);

  localparam int NWIN = IFMAP_W - 2;
  localparam int KW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NWIN - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FILTER, S_IFMAP, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [23:0]        filt_q, filt_d;
  logic [IFMAP_W-1:0] ifm_q, ifm_d;
  logic [25:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [IFMAP_W-1:0] win_sh;
  logic               hs;

  assign hs = valid_q & pkt_ready_i;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    filt_d  = filt_q;
    ifm_d   = ifm_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        filt_d  = filter_in_i;
        ifm_d   = ifmap_in_i;
        k_d     = '0;
        state_d = SEND_CLEAR ? S_CLEAR : S_FILTER;
      end
      S_CLEAR:  if (hs) state_d = S_FILTER;
      S_FILTER: if (hs) state_d = S_IFMAP;
      S_IFMAP: if (hs) begin
        if (k_q == KLAST) state_d = S_DONE;
        else              k_d     = k_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from next state so they come straight off flops;
  // under a stall every input to this block is unchanged, so data holds.
  always_comb begin
    win_sh  = ifm_d >> k_d;
    valid_d = 1'b0;
    data_d  = '0;
    done_d  = (state_d == S_DONE);
    case (state_d)
      S_CLEAR:  valid_d = 1'b1;
      S_FILTER: begin
        valid_d = 1'b1;
        data_d  = {2'b10, filt_d};
      end
      S_IFMAP: begin
        valid_d = 1'b1;
        data_d  = {2'b11, 21'd0, win_sh[2:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      filt_q  <= '0;
      ifm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      filt_q  <= filt_d;
      ifm_q   <= ifm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign idle_o      = (state_q == S_IDLE);
  assign pkt_data_o  = data_q;
  assign pkt_valid_o = valid_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_pe_packet_sender.sv
// Bench for pe_packet_sender: two configurations (W=8 with clear, W=3 without)
// checked against a packet-list model with stall/stability and done timing.
module tb_pe_packet_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, ready, sel;
  logic [23:0] f_in;
  logic [7:0]  m_in;

  logic        idle_a, valid_a, done_a, idle_b, valid_b, done_b;
  logic [25:0] data_a, data_b;

  pe_packet_sender #(.IFMAP_W(8), .SEND_CLEAR(1'b1)) dut_a (
    .clk_i(clk), .reset_i(reset), .start_i(start & ~sel),
    .filter_in_i(f_in), .ifmap_in_i(m_in),
    .idle_o(idle_a), .pkt_data_o(data_a), .pkt_valid_o(valid_a),
    .pkt_ready_i(ready), .done_o(done_a));

  pe_packet_sender #(.IFMAP_W(3), .SEND_CLEAR(1'b0)) dut_b (
    .clk_i(clk), .reset_i(reset), .start_i(start & sel),
    .filter_in_i(f_in), .ifmap_in_i(m_in[2:0]),
    .idle_o(idle_b), .pkt_data_o(data_b), .pkt_valid_o(valid_b),
    .pkt_ready_i(ready), .done_o(done_b));

  wire        idle  = sel ? idle_b  : idle_a;
  wire        valid = sel ? valid_b : valid_a;
  wire        done  = sel ? done_b  : done_a;
  wire [25:0] data  = sel ? data_b  : data_a;

  typedef struct {
    bit          sel;
    logic [23:0] f;
    logic [7:0]  m;
    int          mode;      // 0 ready=1, 1 pattern 1,0,0, 2 random
    int          inject;    // cycle to pulse a stray start (0 = none)
    int          exp_npk;
    logic [25:0] exp_last;
    int          exp_done;  // start-to-done cycles (0 = not checked)
  } vec_t;

  int checks = 0, errors = 0;
  logic [25:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packet list straight from the packet format rules.
  task automatic push_job(input logic [23:0] f, input logic [7:0] m, input int w, input bit sc);
    if (sc) exp_q.push_back(26'h0);
    exp_q.push_back({2'b10, f});
    for (int k = 0; k <= w - 3; k++)
      exp_q.push_back({2'b11, 24'((m >> k) & 8'd7)});
  endtask

  task automatic run_job(input vec_t v);
    int   nrx = 0;
    logic [25:0] last_rx = '0, held = '0;
    bit   stall = 0, got_done = 0;
    push_job(v.f, v.m, v.sel ? 3 : 8, v.sel ? 1'b0 : 1'b1);
    sel = v.sel; start = 1'b1; f_in = v.f; m_in = v.m;
    @(posedge clk); #1;
    start = 1'b0; f_in = $urandom; m_in = $urandom;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      case (v.mode)
        0: ready = 1'b1;
        1: ready = ((cyc - 1) % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == v.inject) begin
        start = 1'b1; f_in = $urandom; m_in = $urandom;
      end else start = 1'b0;
      if (cyc == 1) begin
        chk("first_valid", 32'(valid), 32'd1);
        chk("busy_idle", 32'(idle), 32'd0);
      end
      if (stall) begin
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_data", 32'(data), 32'(held));
      end
      stall = 0;
      if (done) begin
        got_done = 1;
        if (v.exp_done > 0) chk("done_latency", 32'(cyc), 32'(v.exp_done));
        break;
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) chk("extra_pkt", 32'(data), 32'hFFFF_FFFF);
        else chk("pkt", 32'(data), 32'(exp_q.pop_front()));
        nrx++; last_rx = data;
      end else if (valid) begin
        stall = 1; held = data;
      end
    end
    start = 1'b0;
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    chk("pkt_count", 32'(nrx), 32'(v.exp_npk));
    chk("last_pkt", 32'(last_rx), 32'(v.exp_last));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after", 32'(idle), 32'd1);
    chk("valid_after", 32'(valid), 32'd0);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    vecs[0] = '{0, 24'h030201, 8'b1011_0110, 0, 0, 8, 26'h3000005, 9};
    vecs[1] = '{0, 24'h030201, 8'b1011_0110, 1, 0, 8, 26'h3000005, 0};
    vecs[2] = '{0, 24'h030201, 8'b1011_0110, 0, 5, 8, 26'h3000005, 9};
    vecs[3] = '{1, 24'hFFFFFF, 8'b0000_0111, 0, 0, 2, 26'h3000007, 3};
    vecs[4] = '{0, 24'h123456, 8'hFF,        2, 0, 8, 26'h3000007, 0};

    reset = 1'b1; start = 1'b0; ready = 1'b1; sel = 1'b0; f_in = '0; m_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_data_a", 32'(data_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_idle_a", 32'(idle_a), 32'd1);
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    chk("rst_idle_b", 32'(idle_b), 32'd1);

    // Reset and start together: reset wins.
    start = 1'b1; f_in = 24'h111111; m_in = 8'h55;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", 32'(idle_a), 32'd1);
    chk("rst_start_valid", 32'(valid_a), 32'd0);

    // Table vectors run back-to-back: each start lands on the first IDLE cycle.
    foreach (vecs[i]) run_job(vecs[i]);

    // Reset while FILTER is stalled.
    sel = 1'b0; ready = 1'b0; start = 1'b1; f_in = 24'hABCDEF; m_in = 8'h3C;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("rs_clear", 32'(data_a), 32'd0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("rs_filter", 32'(data_a), 32'({2'b10, 24'hABCDEF}));
    @(negedge clk);
    chk("rs_filter_hold", 32'(valid_a), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_valid", 32'(valid_a), 32'd0);
    chk("rs_idle", 32'(idle_a), 32'd1);
    chk("rs_done", 32'(done_a), 32'd0);
    @(negedge clk);
    chk("rs_done2", 32'(done_a), 32'd0);
    run_job(vecs[0]);

    // Random jobs on either configuration with random backpressure.
    for (int n = 0; n < 8; n++) begin
      rv.sel  = 1'($urandom_range(0, 1));
      rv.f    = 24'($urandom);
      rv.m    = 8'($urandom);
      rv.mode = 2;
      rv.inject = 0;
      rv.exp_npk  = rv.sel ? 2 : 8;
      rv.exp_last = {2'b11, 24'((rv.m >> (rv.sel ? 0 : 5)) & 8'd7)};
      rv.exp_done = 0;
      run_job(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_packet_sender.md
# pe_packet_sender

Clocked transmitter that builds and issues the 26-bit packet stream consumed by a PE function unit. On `start` it captures one 3-tap filter row and one ifmap spike row. It then sends a clear packet, a filter packet, and one ifmap packet per stride-1 window, all over a valid/ready channel. It sits between the row buffers and each PE input port.

## Interface
- `IFMAP_W`, 8: ifmap row width in spike bits; legal range 3..64. Window count `NWIN = IFMAP_W-2`.
- `SEND_CLEAR`, 1: 1 = precede every job with a clear packet; 0 = skip it.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  job request; accepted only when `idle`=1.
- `filter_in`  in  24  weights: [23:16] tap2, [15:8] tap1, [7:0] tap0.
- `ifmap_in`  in  IFMAP_W  spike row, bit k = pixel k.
- `idle`  out  1  FSM in IDLE; job can be accepted.
- `pkt_data`  out  26  packet: [25] valid/clear flag, [24] type (0 filter, 1 ifmap), [23:0] payload.
- `pkt_valid`  out  1  packet presented.
- `pkt_ready`  in  1  PE accepts packet.
- `done`  out  1  one-cycle pulse after the last ifmap packet handshakes.

## Operation
- States: IDLE, CLEAR, FILTER, IFMAP, DONE.
- IDLE: `pkt_valid`=0, `idle`=1.
  - On `start`=1, register `filter_in` and `ifmap_in`, and set window index `k`=0.
  - Next state is CLEAR if `SEND_CLEAR`, else FILTER.
- CLEAR: `pkt_data` = 26'h0 (bit25=0). On handshake, go to FILTER.
- FILTER: `pkt_data` = {1'b1, 1'b0, filter_reg}. On handshake, go to IFMAP.
- IFMAP: `pkt_data` = {1'b1, 1'b1, 16'h0, 5'b0, ifmap_reg[k+2:k]}. Window bit2 = pixel k+2, which pairs with tap2 at the PE.
  - On handshake with `k` < NWIN-1: `k` increments and the state stays IFMAP.
  - On handshake with `k` = NWIN-1: go to DONE.
- DONE: `done`=1 for exactly one cycle, `pkt_valid`=0. Next state is IDLE.
- Handshake rules:
  - A transfer occurs on a rising edge where `pkt_valid`=1 and `pkt_ready`=1.
  - While `pkt_valid`=1 and `pkt_ready`=0, `pkt_data` is held bit-stable and `pkt_valid` stays 1.
- `start` is ignored outside IDLE. Captured registers do not change during a job even if the inputs toggle.
- `k` width is clog2(NWIN), minimum 1. `k` never exceeds NWIN-1 and never wraps.
- Unused payload bits are always 0.
- Packets per job = NWIN + 1 + `SEND_CLEAR`.

## Timing
- Reset values: `pkt_valid`=0, `pkt_data`=0, `done`=0, `idle`=1; state=IDLE, `k`=0, captured registers=0.
- Reset is synchronous and overrides everything, including mid-packet. The next cycle has `pkt_valid`=0 even if a handshake was in progress; the packet is dropped and no `done` is produced.
- `pkt_data` and `pkt_valid` are registered outputs. No combinational path exists from `pkt_ready` to any output.
- Start latency: `start` is sampled at edge N. The first packet is valid from edge N+1.
- Throughput: with `pkt_ready` held at 1, one packet transfers per cycle.
  - `done` asserts the cycle after the final transfer.
  - `idle` returns the cycle after that.
- Job length with no backpressure, `SEND_CLEAR`=1: `start` edge to `done` = NWIN+3 cycles.
- Back-to-back jobs: `start` asserted in the first IDLE cycle is accepted. The minimum gap between jobs is one IDLE cycle.
- Simultaneous `start` and `reset`: reset wins; the job is not captured.

## Test plan
- Reset, then hold `pkt_ready`=1. Send `start` with `filter_in`=24'h030201 and `ifmap_in`=8'b1011_0110, IFMAP_W=8.
  - Required stream: 26'h0; 26'h2030201; then ifmap payloads 3'b110, 3'b011, 3'b101, 3'b110, 3'b011, 3'b101 (windows k=0..5), each with [25:24]=2'b11.
  - Required timing: `done` pulses exactly once, 9 cycles after `start`.
- Same job with `pkt_ready` toggling 1,0,0,1,…:
  - No packet is duplicated or lost.
  - `pkt_data` stays stable through every stall cycle.
  - The same 8 packets arrive in order.
- `start` pulsed in the middle of IFMAP with different `filter_in`/`ifmap_in`: ignored. The current job's packets are unchanged and only one `done` is produced.
- `reset` asserted while `pkt_valid`=1, `pkt_ready`=0 in FILTER:
  - Next cycle `pkt_valid`=0, `idle`=1, no `done`.
  - A new job then runs cleanly from CLEAR.
- SEND_CLEAR=0, IFMAP_W=3, `filter_in`=24'hFFFFFF, `ifmap_in`=3'b111: exactly 2 packets, 26'h2FFFFFF then 26'h3000007, then `done`.
- Back-to-back: assert `start` on the first IDLE cycle after `done`. The second job is accepted and its first packet is valid on the next cycle.
